// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache with word-by-word line refill and early restart.
// Optional ICACHE_PERF_EN adds saturating hit/miss/abort counters.
module icache_direct_mapped #(
    parameter int ADDR_WIDTH     = 17,
    parameter int LEN            = 32,
    parameter int NUM_LINES      = 16,
    parameter int INDEX_SIZE     = 4,
    parameter int WORDS_PER_LINE = 4,
    parameter int OFFSET_SIZE    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  inst_fetch_enabled,
    input  logic                  invalidate,
    output logic [LEN-1:0]        instruction,
    output logic [1:0]            inst_fetch_status,
    input  logic [LEN-1:0]        mem_data,
    input  logic [1:0]            mem_status,
    output logic [ADDR_WIDTH-1:0] mem_vis_addr,
    output logic [1:0]            mem_vis_signal
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
    output logic [31:0]           abort_count
`endif
);

    localparam int TAG_W = ADDR_WIDTH - INDEX_SIZE - OFFSET_SIZE - 2;
    localparam logic [OFFSET_SIZE-1:0] LAST_WORD = OFFSET_SIZE'(WORDS_PER_LINE - 1);

    localparam logic [1:0] I_CACHE_RESTING = 2'd0;
    localparam logic [1:0] I_CACHE_WORKING = 2'd1;
    localparam logic [1:0] I_CACHE_STALL   = 2'd2;
    localparam logic [1:0] IF_FINISHED     = 2'd3;
    localparam logic [1:0] MEM_RESTING     = 2'd0;
    localparam logic [1:0] MEM_NOP         = 2'd0;
    localparam logic [1:0] MEM_READ        = 2'd1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e                 state;
    logic [NUM_LINES-1:0]   valid;
    logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
    logic [LEN-1:0]         data_mem [NUM_LINES][WORDS_PER_LINE];

    logic [TAG_W-1:0]       req_tag;
    logic [INDEX_SIZE-1:0]  req_idx;
    logic [OFFSET_SIZE-1:0] req_off;
    logic [OFFSET_SIZE-1:0] cnt;
    logic                   delivered;
    logic                   inv_seen;

    logic [OFFSET_SIZE-1:0] f_off;
    logic [INDEX_SIZE-1:0]  f_idx;
    logic [TAG_W-1:0]       f_tag;
    logic                   unused_addr_bits;

    assign f_off = inst_addr[OFFSET_SIZE+1:2];
    assign f_idx = inst_addr[OFFSET_SIZE+2 +: INDEX_SIZE];
    assign f_tag = inst_addr[ADDR_WIDTH-1 -: TAG_W];
    assign unused_addr_bits = ^inst_addr[1:0];

    logic lookup_ok, idle_hit, idle_miss;
    logic bg_req, bg_match, bg_hit, bg_now, bg_hold, bg_abort;

    // No lookup in the IF_FINISHED cycle, so a still-held request is not served twice.
    // Fetches during a background refill: hit on written words, wait on pending ones, abort otherwise.
    always_comb begin
        lookup_ok = inst_fetch_enabled && (inst_fetch_status != IF_FINISHED);
        idle_hit  = (state == IDLE) && lookup_ok && valid[f_idx] && (tag_mem[f_idx] == f_tag) && !invalidate;
        idle_miss = (state == IDLE) && lookup_ok && !idle_hit;
        bg_req    = (state != IDLE) && delivered && lookup_ok;
        bg_match  = (f_tag == req_tag) && (f_idx == req_idx) && !inv_seen && !invalidate;
        bg_hit    = bg_req && bg_match && (f_off < cnt);
        bg_now    = bg_req && bg_match && (state == WAIT) && (f_off == cnt);
        bg_hold   = bg_req && bg_match && ((state == REQ) ? (f_off >= cnt) : (f_off > cnt));
        bg_abort  = bg_req && !bg_match && !((state == WAIT) && (cnt == LAST_WORD));
    end

    always_ff @(posedge clk) begin
        if (state == WAIT) begin
            data_mem[req_idx][cnt] <= mem_data;
            if (cnt == LAST_WORD) tag_mem[req_idx] <= req_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            valid             <= '0;
            instruction       <= '0;
            mem_vis_addr      <= '0;
            mem_vis_signal    <= MEM_NOP;
            inst_fetch_status <= I_CACHE_RESTING;
            req_tag           <= '0;
            req_idx           <= '0;
            req_off           <= '0;
            cnt               <= '0;
            delivered         <= 1'b0;
            inv_seen          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_vis_signal <= MEM_NOP;
                    if (idle_hit) begin
                        instruction       <= data_mem[f_idx][f_off];
                        inst_fetch_status <= IF_FINISHED;
                    end else if (idle_miss) begin
                        req_tag           <= f_tag;
                        req_idx           <= f_idx;
                        req_off           <= f_off;
                        cnt               <= '0;
                        delivered         <= 1'b0;
                        inv_seen          <= 1'b0;
                        valid[f_idx]      <= 1'b0;
                        inst_fetch_status <= I_CACHE_WORKING;
                        state             <= REQ;
                    end else begin
                        inst_fetch_status <= I_CACHE_RESTING;
                    end
                end
                REQ: begin
                    if (bg_abort) begin
                        mem_vis_signal    <= MEM_NOP;
                        inst_fetch_status <= I_CACHE_WORKING;
                        state             <= IDLE;
                    end else if (mem_status == MEM_RESTING) begin
                        mem_vis_signal    <= MEM_READ;
                        mem_vis_addr      <= {req_tag, req_idx, cnt, 2'b00};
                        inst_fetch_status <= I_CACHE_WORKING;
                        state             <= WAIT;
                    end else begin
                        mem_vis_signal    <= MEM_NOP;
                        inst_fetch_status <= (delivered && !bg_hold) ? I_CACHE_WORKING : I_CACHE_STALL;
                    end
                    if (bg_hit) begin
                        instruction       <= data_mem[req_idx][f_off];
                        inst_fetch_status <= IF_FINISHED;
                    end
                    if (bg_hold) begin
                        req_off   <= f_off;
                        delivered <= 1'b0;
                    end
                    if (invalidate) inv_seen <= 1'b1;
                end
                WAIT: begin
                    mem_vis_signal <= MEM_NOP;
                    if (!delivered && (cnt == req_off)) begin
                        instruction       <= mem_data;
                        inst_fetch_status <= IF_FINISHED;
                        delivered         <= 1'b1;
                    end else begin
                        inst_fetch_status <= (cnt == LAST_WORD) ? I_CACHE_RESTING : I_CACHE_WORKING;
                    end
                    if (bg_hit) begin
                        instruction       <= data_mem[req_idx][f_off];
                        inst_fetch_status <= IF_FINISHED;
                    end
                    if (bg_now) begin
                        instruction       <= mem_data;
                        inst_fetch_status <= IF_FINISHED;
                    end
                    if (bg_hold) begin
                        req_off   <= f_off;
                        delivered <= 1'b0;
                    end
                    if (bg_abort) begin
                        inst_fetch_status <= I_CACHE_WORKING;
                        state             <= IDLE;
                    end else if (cnt == LAST_WORD) begin
                        valid[req_idx] <= !inv_seen && !invalidate;
                        state          <= IDLE;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= REQ;
                    end
                    if (invalidate) inv_seen <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (invalidate) valid <= '0;
        end
    end

`ifdef ICACHE_PERF_EN
    logic hit_ev, miss_ev, abort_ev;
    assign hit_ev   = idle_hit || bg_hit || bg_now;
    assign miss_ev  = idle_miss;
    assign abort_ev = bg_abort;

    // A lookup on the same edge as invalidate is counted after the clear.
    function automatic logic [31:0] bump(input logic [31:0] c, input logic ev, input logic clr);
        if (clr) return {31'b0, ev};
        return (ev && (c != '1)) ? c + 32'd1 : c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count   <= '0;
            miss_count  <= '0;
            abort_count <= '0;
        end else begin
            hit_count   <= bump(hit_count, hit_ev, invalidate);
            miss_count  <= bump(miss_count, miss_ev, invalidate);
            abort_count <= bump(abort_count, abort_ev, invalidate);
        end
    end
`endif

endmodule
